// File: rtl/latch_bank_arbiter_pkg.sv
// Shared definitions for the latch bank arbiter: sequencer state encoding and
// default sizing.
package latch_bank_arbiter_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  // Encoding 2'd3 is unreachable; the sequencer decodes it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;
endpackage

// File: rtl/latch_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [IDXW-1:0] winner_o,
  output logic            valid_o
);
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = |req_i;
    // Walk farthest-to-nearest so the nearest candidate after 'last' wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) winner_o = IDXW'(idx);
    end
  end
endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbitrated writer for one shared q/qbar storage register;
// each grant is a 3-cycle IDLE -> WRITE -> ACK sequence.
module latch_bank_arbiter
  import latch_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [IDXW-1:0]       owner,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar
);
  state_e                       state_q, state_d;
  logic [IDXW-1:0]              last_q, owner_q, win;
  logic                         any_req;
  logic [WIDTH-1:0]             hold_q, q_q;
  logic [NREQ-1:0]              ack_q;
  logic                         busy_q;
  logic                         cap_en, wr_en, done;
  logic [NREQ-1:0][WIDTH-1:0]   wdata_a;

  assign wdata_a = wdata;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (win),
    .valid_o  (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = any_req ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cap_en = (state_q == ST_IDLE) && any_req;
    wr_en  = (state_q == ST_WRITE);
    done   = (state_q == ST_ACK);
  end

  // Pointer starts at NREQ-1 so requester 0 has first priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= IDXW'(NREQ - 1);
      owner_q <= '0;
      hold_q  <= '0;
      q_q     <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      if (cap_en) begin
        hold_q  <= wdata_a[win];
        owner_q <= win;
        busy_q  <= 1'b1;
      end
      if (wr_en) begin
        q_q            <= hold_q;
        ack_q[owner_q] <= 1'b1;
      end
      if (done) begin
        last_q <= owner_q;
        busy_q <= 1'b0;
      end
    end
  end

  // Single stored value with a derived complement: q/qbar can never agree.
  assign q     = q_q;
  assign qbar  = ~q_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Self-checking bench for latch_bank_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_latch_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [IDXW-1:0]       owner;
  logic [WIDTH-1:0]      q, qbar;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase counts cycles since a grant (0 = waiting for one).
  int               m_phase, m_last, m_owner;
  logic [WIDTH-1:0] m_q, m_hold;
  logic [NREQ-1:0]  m_ack;
  logic             m_busy;

  latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .ack(ack), .busy(busy), .owner(owner), .q(q), .qbar(qbar)
  );

  always #5 clk = ~clk;

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] d;
    logic                  rs;
    int                    w;
    r = req; d = wdata; rs = rst;
    @(posedge clk);
    if (rs) begin
      m_phase = 0; m_last = NREQ - 1; m_owner = 0;
      m_q = '0; m_hold = '0; m_ack = '0; m_busy = 1'b0;
    end else if (m_phase == 0) begin
      w = rr_winner(r, m_last);
      if (w >= 0) begin
        m_hold = d[w*WIDTH +: WIDTH]; m_owner = w; m_busy = 1'b1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_q = m_hold; m_ack = '0; m_ack[m_owner] = 1'b1; m_phase = 2;
    end else begin
      m_last = m_owner; m_ack = '0; m_busy = 1'b0; m_phase = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if ({q, qbar, ack, busy, owner} !== {8'h00, 8'hFF, 4'h0, 1'b0, 2'd0}) begin
        n_err++;
        $display("FAIL reset c%0d: q=%h qbar=%h ack=%b busy=%b owner=%0d, need 00 ff 0000 0 0",
                 c, q, qbar, ack, busy, owner);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; wdata = '0; wdata[2*WIDTH +: WIDTH] = 8'hA5;
    tick();
    n_cmp++;
    if ({busy, owner, ack} !== {1'b1, 2'd2, 4'b0000}) begin
      n_err++; $display("FAIL single_e0: busy=%b owner=%0d ack=%b, need 1 2 0000", busy, owner, ack);
    end
    tick();
    n_cmp++;
    if ({q, qbar, ack, busy} !== {8'hA5, 8'h5A, 4'b0100, 1'b1}) begin
      n_err++; $display("FAIL single_e1: q=%h qbar=%h ack=%b busy=%b, need a5 5a 0100 1", q, qbar, ack, busy);
    end
    req = '0;
    tick();
    n_cmp++;
    if ({ack, busy, q} !== {4'b0000, 1'b0, 8'hA5}) begin
      n_err++; $display("FAIL single_e2: ack=%b busy=%b q=%h, need 0000 0 a5", ack, busy, q);
    end
  endtask

  task automatic test_all_held();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      logic [WIDTH-1:0] ev;
      logic [NREQ-1:0]  ea;
      ev = 8'(8'h10 + (k % NREQ));
      ea = 4'(1 << (k % NREQ));
      tick();
      n_cmp++;
      if ({owner, busy} !== {IDXW'(k % NREQ), 1'b1}) begin
        n_err++; $display("FAIL rr_grant k%0d: owner=%0d busy=%b, need %0d 1", k, owner, busy, k % NREQ);
      end
      tick();
      n_cmp++;
      if ({ack, q, qbar} !== {ea, ev, ~ev}) begin
        n_err++; $display("FAIL rr_ack k%0d: ack=%b q=%h qbar=%h, need %b %h %h", k, ack, q, qbar, ea, ev, ~ev);
      end
      tick();
      n_cmp++;
      if ({ack, busy} !== 5'b0) begin
        n_err++; $display("FAIL rr_done k%0d: ack=%b busy=%b, need 0000 0", k, ack, busy);
      end
    end
    req = '0;
  endtask

  task automatic test_pulse_capture();
    do_reset();
    req = 4'b0010; wdata = '0; wdata[1*WIDTH +: WIDTH] = 8'h3C;
    tick();
    req = '0; wdata[1*WIDTH +: WIDTH] = 8'hFF;
    tick();
    n_cmp++;
    if ({q, ack} !== {8'h3C, 4'b0010}) begin
      n_err++; $display("FAIL pulse_write: q=%h ack=%b, need 3c 0010", q, ack);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({q, ack, busy} !== {8'h3C, 4'b0000, 1'b0}) begin
        n_err++; $display("FAIL pulse_quiet c%0d: q=%h ack=%b busy=%b, need 3c 0000 0", c, q, ack, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0001; wdata = '0; wdata[0 +: WIDTH] = 8'h11;
    tick(); tick();
    req = '0;
    tick();
    // Requester 0 was last served; now requester 1 starts and is reset in WRITE.
    req = 4'b0010; wdata[1*WIDTH +: WIDTH] = 8'h77;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({q, qbar, ack, busy} !== {8'h00, 8'hFF, 4'b0000, 1'b0}) begin
        n_err++; $display("FAIL midrst c%0d: q=%h qbar=%h ack=%b busy=%b, need 00 ff 0000 0", c, q, qbar, ack, busy);
      end
      tick();
    end
    req = 4'b1001; wdata[0 +: WIDTH] = 8'hAA; wdata[3*WIDTH +: WIDTH] = 8'hBB;
    tick();
    n_cmp++;
    if (owner !== 2'd0) begin
      n_err++; $display("FAIL midrst_ptr: owner=%0d, need 0", owner);
    end
    tick();
    n_cmp++;
    if ({ack, q} !== {4'b0001, 8'hAA}) begin
      n_err++; $display("FAIL midrst_w0: ack=%b q=%h, need 0001 aa", ack, q);
    end
    req = 4'b1000;
    tick(); tick();
    n_cmp++;
    if (owner !== 2'd3) begin
      n_err++; $display("FAIL midrst_next: owner=%0d, need 3", owner);
    end
    tick();
    n_cmp++;
    if ({ack, q} !== {4'b1000, 8'hBB}) begin
      n_err++; $display("FAIL midrst_w3: ack=%b q=%h, need 1000 bb", ack, q);
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001; wdata = '0;
    wdata[0 +: WIDTH] = 8'hC0; wdata[2*WIDTH +: WIDTH] = 8'hC2;
    tick();
    req = 4'b0101;
    tick(); tick(); tick();
    n_cmp++;
    if ({owner, busy} !== {2'd2, 1'b1}) begin
      n_err++; $display("FAIL b2b_grant2: owner=%0d busy=%b, need 2 1", owner, busy);
    end
    tick();
    n_cmp++;
    if ({ack, q} !== {4'b0100, 8'hC2}) begin
      n_err++; $display("FAIL b2b_ack2: ack=%b q=%h, need 0100 c2", ack, q);
    end
    req = 4'b0001;
    tick(); tick();
    n_cmp++;
    if (owner !== 2'd0) begin
      n_err++; $display("FAIL b2b_grant0: owner=%0d, need 0", owner);
    end
    tick();
    n_cmp++;
    if ({ack, q} !== {4'b0001, 8'hC0}) begin
      n_err++; $display("FAIL b2b_ack0: ack=%b q=%h, need 0001 c0", ack, q);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_ack[i]) req[i] = ($urandom_range(2, 0) == 0);
        else if (!req[i])       req[i] = ($urandom_range(3, 0) == 0);
      end
      wdata = {$urandom};
      rst = ($urandom_range(96, 0) == 0);
      tick();
      n_cmp++;
      if ({q, qbar, ack, busy} !== {m_q, ~m_q, m_ack, m_busy} ||
          (m_busy && owner !== IDXW'(m_owner))) begin
        n_err++;
        $display("FAIL random c%0d: q=%h qbar=%h ack=%b busy=%b owner=%0d, need %h %h %b %b %0d",
                 c, q, qbar, ack, busy, owner, m_q, ~m_q, m_ack, m_busy, m_owner);
      end
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; wdata = '0;
    test_reset();
    test_single();
    test_all_held();
    test_pulse_capture();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
